// File: rtl/fixed_point_alu_if.sv
// Operand, command and result bundle between the bus adapter and the fixed-point ALU.
interface fixed_point_alu_if #(parameter int N = 16);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/fixed_point_alu.sv
// Signed Q(I).(F) ALU: ADD/SUB/NEG in one step, shift-add MUL over N cycles,
// restoring DIV over N+F cycles; one-cycle done pulse, result held until the next FINISH.
module fixed_point_alu #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  fixed_point_alu_if.slave   bus
);
  localparam int N  = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
  localparam int F  = FRACTIONAL_PART_WIDTH;
  localparam int D  = N + F;
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             neg, neg_n;
  logic [N-1:0]     mag_a, mag_a_n;
  logic [N-1:0]     mag_b, mag_b_n;
  logic [2*N-1:0]   prod, prod_n;
  logic [N-1:0]     rem, rem_n;
  logic [D-1:0]     dvd, dvd_n;
  logic [N-1:0]     result, result_n;

  logic [N-1:0]     mag_a_in, mag_b_in, quo;
  logic [N:0]       mul_sum, trial, diff;
  logic             qbit;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    neg_n    = neg;
    mag_a_n  = mag_a;
    mag_b_n  = mag_b;
    prod_n   = prod;
    rem_n    = rem;
    dvd_n    = dvd;
    result_n = result;
    mul_sum  = '0;
    trial    = '0;
    diff     = '0;
    qbit     = 1'b0;
    quo      = '0;
    mag_a_in = bus.a[N-1] ? -bus.a : bus.a;
    mag_b_in = bus.b[N-1] ? -bus.b : bus.b;

    case (state)
      // FINISH accepts a new start exactly like IDLE so back-to-back issue works.
      S_IDLE, S_FINISH: begin
        state_n = S_IDLE;
        if (bus.start) begin
          neg_n   = bus.a[N-1] ^ bus.b[N-1];
          mag_a_n = mag_a_in;
          mag_b_n = mag_b_in;
          cnt_n   = '0;
          state_n = S_FINISH;
          case (bus.op)
            3'd0: result_n = bus.a + bus.b;
            3'd1: result_n = bus.a - bus.b;
            3'd4: result_n = -bus.a;
            3'd2: begin
              prod_n  = {{N{1'b0}}, mag_b_in};
              state_n = S_MUL;
            end
            3'd3: begin
              if (bus.b == '0) begin
                result_n = bus.a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
              end else begin
                rem_n   = '0;
                dvd_n   = {mag_a_in, {F{1'b0}}};
                state_n = S_DIV;
              end
            end
            default: result_n = '0;
          endcase
        end
      end
      S_MUL: begin
        // Multiplier sits in the low half and drains out as partial sums shift in.
        mul_sum = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mag_a} : {(N+1){1'b0}});
        prod_n  = {mul_sum, prod[N-1:1]};
        cnt_n   = cnt + 1'b1;
        if (cnt == CW'(N - 1)) begin
          quo      = prod_n[N+F-1:F];
          result_n = neg ? -quo : quo;
          state_n  = S_FINISH;
        end
      end
      S_DIV: begin
        trial = {rem, dvd[D-1]};
        diff  = trial - {1'b0, mag_b};
        qbit  = ~diff[N];
        rem_n = qbit ? diff[N-1:0] : trial[N-1:0];
        dvd_n = {dvd[D-2:0], qbit};
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(D - 1)) begin
          quo      = dvd_n[N-1:0];
          result_n = neg ? -quo : quo;
          state_n  = S_FINISH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      neg    <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      prod   <= '0;
      rem    <= '0;
      dvd    <= '0;
      result <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      neg    <= neg_n;
      mag_a  <= mag_a_n;
      mag_b  <= mag_b_n;
      prod   <= prod_n;
      rem    <= rem_n;
      dvd    <= dvd_n;
      result <= result_n;
    end
  end

  assign bus.busy   = (state == S_MUL) || (state == S_DIV);
  assign bus.done   = (state == S_FINISH);
  assign bus.result = result;
endmodule

// File: tb/tb_fixed_point_alu.sv
// Bench for fixed_point_alu: directed vectors, randomized ops against an arithmetic model,
// start-ignore, back-to-back issue and reset abort.
module tb_fixed_point_alu;
  localparam int N = 16;
  localparam int F = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fixed_point_alu_if #(.N(N)) bus();
  fixed_point_alu #(.INTEGER_PART_WIDTH(8), .FRACTIONAL_PART_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [N-1:0] ref_model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    longint sa, sb, ma, mb, r, modn;
    bit neg;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ma   = (sa < 0) ? -sa : sa;
    mb   = (sb < 0) ? -sb : sb;
    neg  = (sa < 0) != (sb < 0);
    modn = 64'sd1 << N;
    r    = 0;
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd4: r = -sa;
      3'd2: begin
        r = ((ma * mb) >> F) % modn;
        if (neg) r = -r;
      end
      3'd3: begin
        if (sb == 0) r = (sa >= 0) ? (modn / 2) - 1 : -(modn / 2);
        else begin
          r = ((ma << F) / mb) % modn;
          if (neg) r = -r;
        end
      end
      default: r = 0;
    endcase
    return r[N-1:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [N-1:0] b);
    if (op == 3'd2) return N + 1;
    if (op == 3'd3 && b != '0) return N + F + 1;
    return 1;
  endfunction

  task automatic launch(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int k, output int busy_cyc);
    k = k0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && k < 60) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] res, output int lat, output int bc);
    launch(op, a, b);
    wait_done(1, lat, bc);
    res = bus.result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", bus.result); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]   v_op [12] = '{3'd0, 3'd1, 3'd0, 3'd4, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd2};
    logic [N-1:0] v_a  [12] = '{16'h0180, 16'h0180, 16'h7F00, 16'h8000, 16'h0180, 16'hFE80,
                                16'h0300, 16'hFD00, 16'h0100, 16'hFF00, 16'h1234, 16'h8000};
    logic [N-1:0] v_b  [12] = '{16'h0240, 16'h0240, 16'h0200, 16'h0000, 16'h0240, 16'h0240,
                                16'h0200, 16'h0200, 16'h0000, 16'h0000, 16'h5678, 16'h0100};
    logic [N-1:0] v_r  [12] = '{16'h03C0, 16'hFF40, 16'h8100, 16'h8000, 16'h0360, 16'hFCA0,
                                16'h0180, 16'hFE80, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000};
    int           v_l  [12] = '{1, 1, 1, 1, 17, 17, 25, 25, 1, 1, 1, 17};
    logic [N-1:0] res;
    int lat, bc;
    for (int i = 0; i < 12; i++) begin
      do_op(v_op[i], v_a[i], v_b[i], res, lat, bc);
      n_cmp++; if (res !== v_r[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, v_r[i]); end
      n_cmp++; if (lat != v_l[i]) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, v_l[i]); end
      n_cmp++; if (bc != v_l[i] - 1) begin n_fail++; $display("FAIL directed_busy_cycles[%0d]: got %0d want %0d", i, bc, v_l[i] - 1); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL directed_busy_at_done[%0d]: got %b want 0", i, bus.busy); end
    end
  endtask

  task automatic test_random();
    logic [2:0]   op;
    logic [N-1:0] a, b, res;
    int lat, bc;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      do_op(op, a, b, res, lat, bc);
      n_cmp++; if (res !== ref_model(op, a, b)) begin n_fail++; $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", op, a, b, res, ref_model(op, a, b)); end
      n_cmp++; if (lat != exp_lat(op, b)) begin n_fail++; $display("FAIL random_latency op=%0d: got %0d want %0d", op, lat, exp_lat(op, b)); end
    end
  endtask

  task automatic test_ignored_start();
    int k, bc;
    launch(3'd2, 16'h0180, 16'h0240);
    repeat (4) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 16'h1111; bus.b = 16'h2222;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(6, k, bc);
    n_cmp++; if (k != 17) begin n_fail++; $display("FAIL ignored_start_latency: got %0d want 17", k); end
    n_cmp++; if (bus.result !== 16'h0360) begin n_fail++; $display("FAIL ignored_start_result: got %h want 0360", bus.result); end
  endtask

  task automatic test_back_to_back();
    int k, bc;
    launch(3'd2, 16'h0300, 16'h0200);
    wait_done(1, k, bc);
    n_cmp++; if (bus.result !== 16'h0600) begin n_fail++; $display("FAIL b2b_first_result: got %h want 0600", bus.result); end
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 16'h0100; bus.b = 16'h0400;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.result !== 16'h0600) begin n_fail++; $display("FAIL b2b_result_hold: got %h want 0600", bus.result); end
    wait_done(1, k, bc);
    n_cmp++; if (k != 25) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 25", k); end
    n_cmp++; if (bus.result !== 16'h0040) begin n_fail++; $display("FAIL b2b_second_result: got %h want 0040", bus.result); end
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] res;
    int lat, bc;
    bit seen_done;
    do_op(3'd0, 16'h0100, 16'h0100, res, lat, bc);
    launch(3'd3, 16'h0300, 16'h0200);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.result !== 16'h0000) begin n_fail++; $display("FAIL abort_result: got %h want 0000", bus.result); end
    seen_done = 1'b0;
    repeat (30) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", seen_done); end
    rst = 1'b1; bus.start = 1'b1; bus.op = 3'd0; bus.a = 16'h0001; bus.b = 16'h0002;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_beats_start_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 16'h0000) begin n_fail++; $display("FAIL rst_beats_start_result: got %h want 0000", bus.result); end
    do_op(3'd0, 16'h0180, 16'h0240, res, lat, bc);
    n_cmp++; if (res !== 16'h03C0) begin n_fail++; $display("FAIL post_abort_add: got %h want 03C0", res); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL post_abort_latency: got %0d want 1", lat); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
